// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the SAR ADC controller.
//   sar_state_t : conversion FSM state encoding
//   SYNC_STAGES : depth of the optional comparator synchronizer
//   ch_width()  : channel-select width for a given channel count (minimum 1)
package sar_adc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DECIDE = 2'd2,
    S_DONE   = 2'd3
  } sar_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_comp_sync.sv
// Flop-chain synchronizer for the asynchronous comparator output.
// Resets to 0 asynchronously. Used by sar_adc_ctrl only when SAR_COMP_SYNC_EN
// is defined.
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   i_d   : raw comparator input
//   o_q   : synchronized comparator output (SYNC_STAGES cycles of delay)
module sar_comp_sync
  import sar_adc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller. Drives a trial DAC code and an
// analog mux select, reads back one comparator decision per bit and returns a
// WIDTH-bit result per conversion. Single-shot (i_start) or continuous
// round-robin (i_scan) operation over NCH channels.
//
// Optional build macro SAR_COMP_SYNC_EN: routes i_comp through sar_comp_sync
// and stretches the per-bit settle time by SYNC_STAGES cycles so the decision
// reflects the current trial code. Without it i_comp must be synchronous to clk.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : request one conversion (sampled in IDLE only)
//   i_scan       : continuous mode (sampled in IDLE and at each conversion end)
//   i_ch_sel     : channel (single-shot) or first channel (scan)
//   i_comp       : 1 = analog input >= o_dac_code
//   o_dac_code   : trial code to the DAC
//   o_ch_mux     : analog mux select
//   o_busy       : conversion in progress
//   o_done       : one-cycle pulse, o_dout/o_dout_ch/o_ovr valid
//   o_dout       : last result, held until the next o_done
//   o_dout_ch    : channel of o_dout
//   o_ovr        : every decision was 1 (input at or above full scale)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a valid request; DAC code parked at 0
// S_SETTLE | trial code applied, counting down DAC/comparator settle time
// S_DECIDE | sample comparator, resolve bit k, arm bit k-1 or finish
// S_DONE   | result published with o_done; restart on next channel if scan
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter  int WIDTH  = 7,
  parameter  int NCH    = 4,
  parameter  int SETTLE = 1,
  localparam int CH_W   = ch_width(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_scan,
  input  logic [CH_W-1:0]  i_ch_sel,
  input  logic             i_comp,
  output logic [WIDTH-1:0] o_dac_code,
  output logic [CH_W-1:0]  o_ch_mux,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_dout,
  output logic [CH_W-1:0]  o_dout_ch,
  output logic             o_ovr
);

`ifdef SAR_COMP_SYNC_EN
  localparam int SETTLE_EFF = SETTLE + SYNC_STAGES;
`else
  localparam int SETTLE_EFF = SETTLE;
`endif
  localparam int CNT_LOAD = (SETTLE_EFF > 0) ? SETTLE_EFF - 1 : 0;
  localparam int CNT_W    = (CNT_LOAD > 0) ? $clog2(CNT_LOAD + 1) : 1;
  localparam int K_W      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  // With no settle time a bit goes straight from arming to its decision.
  localparam sar_state_t S_BIT_FIRST = (SETTLE_EFF > 0) ? S_SETTLE : S_DECIDE;

  sar_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_dac_code, w_dac_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]  r_ch_mux, w_ch_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic [CH_W-1:0]  r_dout_ch, w_dout_ch_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             w_comp;
  logic             w_ch_ok;
  logic [WIDTH-1:0] w_code;
  logic [CH_W-1:0]  w_ch_inc;

`ifdef SAR_COMP_SYNC_EN
  sar_comp_sync u_comp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_comp),
    .o_q   (w_comp)
  );
`else
  assign w_comp = i_comp;
`endif

  assign w_ch_ok  = (int'(i_ch_sel) < NCH);
  assign w_ch_inc = (r_ch_mux == CH_W'(NCH - 1)) ? '0 : r_ch_mux + 1'b1;

  // Resolved code for the current decision: bit k takes the comparator
  // result and, if bits remain, the next lower bit is armed for trial.
  always_comb begin
    w_code      = r_dac_code;
    w_code[r_k] = w_comp;
    if (r_k != '0) w_code[r_k - 1'b1] = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dac_nxt     = r_dac_code;
    w_k_nxt       = r_k;
    w_cnt_nxt     = r_cnt;
    w_ch_nxt      = r_ch_mux;
    w_dout_nxt    = r_dout;
    w_dout_ch_nxt = r_dout_ch;
    w_ovr_nxt     = r_ovr;
    case (r_state)
      S_IDLE: begin
        w_dac_nxt = '0;
        if ((i_start || i_scan) && w_ch_ok) begin
          w_ch_nxt    = i_ch_sel;
          w_dac_nxt   = MSB_CODE;
          w_k_nxt     = K_W'(WIDTH - 1);
          w_cnt_nxt   = CNT_W'(CNT_LOAD);
          w_state_nxt = S_BIT_FIRST;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = S_DECIDE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_DECIDE: begin
        w_dac_nxt = w_code;
        if (r_k != '0) begin
          w_k_nxt     = r_k - 1'b1;
          w_cnt_nxt   = CNT_W'(CNT_LOAD);
          w_state_nxt = S_BIT_FIRST;
        end else begin
          // Result is registered here so it is already valid while o_done is high.
          w_dout_nxt    = w_code;
          w_dout_ch_nxt = r_ch_mux;
          w_ovr_nxt     = &w_code;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        if (i_scan) begin
          w_ch_nxt    = w_ch_inc;
          w_dac_nxt   = MSB_CODE;
          w_k_nxt     = K_W'(WIDTH - 1);
          w_cnt_nxt   = CNT_W'(CNT_LOAD);
          w_state_nxt = S_BIT_FIRST;
        end else begin
          w_dac_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dac_code <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_ch_mux   <= '0;
      r_dout     <= '0;
      r_dout_ch  <= '0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dac_code <= w_dac_nxt;
      r_k        <= w_k_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ch_mux   <= w_ch_nxt;
      r_dout     <= w_dout_nxt;
      r_dout_ch  <= w_dout_ch_nxt;
      r_ovr      <= w_ovr_nxt;
    end
  end

  assign o_dac_code = r_dac_code;
  assign o_ch_mux   = r_ch_mux;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_dout     = r_dout;
  assign o_dout_ch  = r_dout_ch;
  assign o_ovr      = r_ovr;

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Parametrised successive-approximation ADC controller. It sequences an external trial DAC and analog comparator across `NCH` multiplexed input channels and produces a `WIDTH`-bit result per conversion. It supports single-shot and continuous round-robin scan modes. The block sits between the analog front end (mux, DAC, comparator) and the digital sample consumer, and supersedes the fixed 7-bit single-compare converter.

## Interface
- `WIDTH`, 7: result and DAC code width (≥2).
- `NCH`, 4: number of analog channels (≥1); `CH_W = max(1, $clog2(NCH))`.
- `SETTLE`, 1: DAC/comparator settle cycles per bit before sampling (≥0).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request one conversion; sampled only in IDLE.
- `scan`  in  1: continuous round-robin mode; sampled in IDLE and at each conversion end.
- `ch_sel`  in  CH_W: channel for single-shot; starting channel for scan.
- `comp`  in  1: comparator, 1 = analog input ≥ `dac_code`.
- `dac_code`  out  WIDTH: trial code driven to the DAC.
- `ch_mux`  out  CH_W: analog mux select.
- `busy`  out  1: conversion in progress.
- `done`  out  1: one-cycle pulse; `dout`, `dout_ch` and `ovr` valid.
- `dout`  out  WIDTH: last result, held until the next `done`.
- `dout_ch`  out  CH_W: channel of `dout`.
- `ovr`  out  1: every bit decision was 1 (input at or above full scale).

## Operation
- States: IDLE, SETTLE, DECIDE, DONE.
- IDLE: `busy`=0, `dac_code`=0. The block accepts a conversion when (`start`|`scan`) && `ch_sel`<NCH. On acceptance: latch the channel to `ch_mux`, set bit index k=WIDTH-1, set `dac_code`=1<<(WIDTH-1), load the settle counter, then go to SETTLE. A request with `ch_sel`≥NCH is ignored.
- SETTLE: count down `SETTLE` cycles, then go to DECIDE. With `SETTLE`=0 the block goes straight to DECIDE.
- DECIDE, one cycle: if `comp`=0, clear bit k. If k>0, set bit k-1, decrement k, reload the counter and go to SETTLE. Otherwise go to DONE.
- DONE, one cycle: `dout`←`dac_code`, `dout_ch`←`ch_mux`, `ovr`←all decisions 1, `done`=1.
  - If `scan`=1: `ch_mux`←(`ch_mux`+1) mod NCH, restart at bit WIDTH-1 (SETTLE).
  - Else: go to IDLE.
- `start` while busy is ignored, not queued. Deasserting `scan` mid-conversion finishes the current conversion, then returns to IDLE.
- Reset values: state IDLE, `dac_code`=0, `ch_mux`=0, `busy`=0, `done`=0, `dout`=0, `dout_ch`=0, `ovr`=0. Asserting reset mid-conversion aborts it immediately; no `done` is produced.

## Timing
- Per bit: `SETTLE`+1 cycles. Conversion latency: `start` sampled at edge 0, `done` high during cycle WIDTH·(SETTLE+1)+1.
- In scan mode, conversions run back-to-back with no IDLE cycle; period WIDTH·(SETTLE+1)+1.
- `busy` is high from the cycle after acceptance through the DONE cycle.
- `dac_code` and `ch_mux` are registered and change only on clock edges.
- The earliest next single-shot `start` is accepted in the cycle after `done`.

## Configuration
- `SAR_COMP_SYNC_EN` defined:
  - `comp` passes through a 2-flop synchronizer before DECIDE.
  - The settle count is extended by 2 cycles per bit.
  - Per bit = `SETTLE`+3 cycles; latency = WIDTH·(SETTLE+3)+1.
- Undefined: `comp` is used directly and the comparator must be synchronous to `clk`.

## Structure
- Package `sar_adc_pkg`: state enum (IDLE/SETTLE/DECIDE/DONE), `SYNC_STAGES`=2 constant, channel-width helper function.
- Sub-module `sar_comp_sync`: 2-flop synchronizer with asynchronous active-low reset to 0, instantiated only under `SAR_COMP_SYNC_EN`.

## Test plan
All scenarios use WIDTH=7, NCH=4, SETTLE=1, macro off, and a comparator model `comp`=(vin[ch_mux] ≥ dac_code).
- vin0=100, `start` pulse with ch_sel=0 → `done` at cycle 15, `dout`=100, `dout_ch`=0, `ovr`=0; `dac_code` sequence 64, 96, 112→104→100.
- vin=0 → `dout`=0. vin=127 → `dout`=127 with `ovr`=1.
- `start` re-pulsed at cycle 5 of a conversion → ignored: exactly one `done`, result unchanged. `ch_sel`=5 with NCH=4 (needs CH_W=3, NCH=5 variant to be invalid) → no `busy`.
- `scan`=1, ch_sel=2, vin={10,20,30,40} → `done` every 15 cycles with `dout_ch` 2,3,0,1 and `dout` 30,40,10,20. Drop `scan` mid-conversion → that conversion completes, then IDLE.
- `rst_n` low at cycle 8 of a conversion → all outputs return to reset values asynchronously, no `done`. After release, a new conversion is correct.
- Macro on, vin=100 → `done` at cycle 7·4+1=29, `dout`=100.
